// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-path PC register with increment/branch/jump/call/return
//            selection and a circular return-address stack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned      c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RAS_DEPTH);
  localparam logic [WIDTH-1:0]   c_step  = WIDTH'(STEP);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [WIDTH-1:0]   r_pc;
  logic [c_ptr_w-1:0] r_top;
  logic [c_cnt_w-1:0] r_count;
  logic               r_ovf;
  logic               r_unf;
  logic [WIDTH-1:0]   r_ras [RAS_DEPTH];

  logic [WIDTH-1:0]   w_inc;
  logic [WIDTH-1:0]   w_pc_next;
  logic [c_ptr_w-1:0] w_push_ptr;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf;
  logic               w_unf;

  assign w_inc      = r_pc + c_step;
  assign w_push_ptr = r_top + c_ptr_one;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_depth);

  // Next-PC selection; each branch of the priority chain owns its side effects.
  always_comb begin
    w_pc_next = w_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (stall) begin
      w_pc_next = r_pc;
    end else if (ret_en) begin
      if (w_empty) begin
        w_unf = 1'b1;
      end else begin
        w_pc_next = r_ras[r_top];
        w_pop     = 1'b1;
      end
    end else if (call_en) begin
      w_pc_next = jump_target;
      w_push    = 1'b1;
      w_ovf     = w_full;
    end else if (jump_en) begin
      w_pc_next = jump_target;
    end else if (branch_en) begin
      w_pc_next = r_pc + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      if (w_push) begin
        r_top <= w_push_ptr;
        // When full, the push lands on the oldest slot, so depth is unchanged.
        if (!w_full) r_count <= r_count + c_cnt_one;
      end else if (w_pop) begin
        r_top   <= r_top - c_ptr_one;
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // Stack storage carries no reset; contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_push_ptr] <= w_inc;
  end

  assign pc        = r_pc;
  assign pc_next   = w_pc_next;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int unsigned      WIDTH     = 32;
  localparam int unsigned      STEP      = 1;
  localparam logic [31:0]      RESET_PC  = 32'h100;
  localparam int unsigned      RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_off = '0;
  logic        jump_en = 1'b0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  pc_sequencer #(
    .WIDTH(WIDTH), .STEP(STEP), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_en(branch_en),
    .branch_off(branch_off), .jump_en(jump_en), .call_en(call_en),
    .ret_en(ret_en), .jump_target(jump_target), .pc(pc), .pc_next(pc_next),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every clock edge produces a new visible state to score.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc", pc, e.pc);
      check("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
      check("ras_full", {31'b0, ras_full}, {31'b0, e.full});
      check("ras_ovf", {31'b0, ras_ovf}, {31'b0, e.ovf});
      check("ras_unf", {31'b0, ras_unf}, {31'b0, e.unf});
    end
  end

  // Reference model: the stack is a list of return addresses, newest at the back.
  task automatic model_and_push(input bit s, input bit br, input logic [31:0] off,
                                input bit j, input bit c, input bit r,
                                input logic [31:0] tgt);
    logic [31:0] inc, nxt;
    bit ovf, unf;
    exp_t e;
    inc = m_pc + 32'(STEP);
    nxt = inc;
    ovf = 0;
    unf = 0;
    if (s) nxt = m_pc;
    else if (r) begin
      if (m_ras.size() == 0) unf = 1;
      else nxt = m_ras.pop_back();
    end else if (c) begin
      if (m_ras.size() == RAS_DEPTH) begin
        void'(m_ras.pop_front());
        ovf = 1;
      end
      m_ras.push_back(inc);
      nxt = tgt;
    end else if (j) nxt = tgt;
    else if (br) nxt = m_pc + off;
    check("pc_next", pc_next, nxt);
    m_pc = nxt;
    e.pc    = nxt;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == RAS_DEPTH);
    e.ovf   = ovf;
    e.unf   = unf;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit s, input bit br, input logic [31:0] off,
                      input bit j, input bit c, input bit r, input logic [31:0] tgt);
    stall = s; branch_en = br; branch_off = off;
    jump_en = j; call_en = c; ret_en = r; jump_target = tgt;
    #1;
    model_and_push(s, br, off, j, c, r, tgt);
    @(negedge clk);
  endtask

  task automatic idle();                     step(0, 0, '0, 0, 0, 0, '0); endtask
  task automatic jump(input logic [31:0] t); step(0, 0, '0, 1, 0, 0, t);  endtask
  task automatic call(input logic [31:0] t); step(0, 0, '0, 0, 1, 0, t);  endtask
  task automatic ret();                      step(0, 0, '0, 0, 0, 1, '0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pc = RESET_PC;
    repeat (2) @(negedge clk);
    check("reset pc", pc, RESET_PC);
    check("reset ras_empty", {31'b0, ras_empty}, 32'd1);
    check("reset ras_full", {31'b0, ras_full}, 32'd0);
    check("reset ras_ovf", {31'b0, ras_ovf}, 32'd0);
    check("reset ras_unf", {31'b0, ras_unf}, 32'd0);
    rst_n = 1'b1;

    repeat (3) idle();

    jump(32'h10);
    step(0, 1, 32'hFFFF_FFF0, 0, 0, 0, '0);
    jump(32'hFFFF_FFFF);
    idle();

    jump(32'h20);
    step(1, 0, '0, 1, 0, 0, 32'h80);
    step(0, 1, 32'h5, 1, 0, 0, 32'h80);

    jump(32'h10);
    call(32'h40);
    call(32'h60);
    ret();
    ret();

    jump(32'h0);
    call(32'h10);
    call(32'h20);
    call(32'h30);
    call(32'h40);
    call(32'h50);
    repeat (4) ret();
    ret();
    idle();

    // Asynchronous reset between edges with two return addresses stacked.
    jump(32'h10);
    call(32'h40);
    call(32'h60);
    stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async pc", pc, RESET_PC);
    check("async ras_empty", {31'b0, ras_empty}, 32'd1);
    m_pc = RESET_PC;
    m_ras.delete();
    #1 rst_n = 1'b1;
    model_and_push(0, 0, '0, 0, 0, 0, '0);
    @(negedge clk);
    ret();
    idle();

    for (int i = 0; i < 400; i++) begin
      bit s, br, j, c, r;
      logic [31:0] off;
      s  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 3) == 0);
      off = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                        : 32'($urandom_range(0, 64)) - 32'd32;
      step(s, br, off, j, c, r, 32'($urandom));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle processor fetch path. Holds the PC register and selects the next PC each cycle: sequential increment by a configurable step, PC-relative branch, absolute jump, or call/return through a small circular return-address stack (RAS). It supplies the instruction-memory address and the current PC to the datapath.

## Interface

**Parameters**
- WIDTH, 32, PC and address width in bits.
- STEP, 1, sequential increment, in address units.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two and at least 2.

**Ports**
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold the PC and RAS this cycle.
- branch_en  input  1  take a PC-relative branch.
- branch_off  input  WIDTH  two's-complement branch offset.
- jump_en  input  1  take an absolute jump.
- call_en  input  1  call: push the return address, then jump to jump_target.
- ret_en  input  1  return: pop the RAS and load the popped address.
- jump_target  input  WIDTH  absolute target for jump_en and call_en.
- pc  output  WIDTH  registered current PC.
- pc_next  output  WIDTH  combinational value that pc takes at the next edge.
- ras_empty  output  1  RAS count is 0.
- ras_full  output  1  RAS count equals RAS_DEPTH.
- ras_ovf  output  1  registered one-cycle pulse: a call was made while the RAS was full.
- ras_unf  output  1  registered one-cycle pulse: a return was made while the RAS was empty.

## Operation

- All arithmetic is modulo 2^WIDTH, with no overflow flag.
  - inc = pc + STEP.
  - Branch target = pc + branch_off (offset relative to the current pc, not to inc).
- Selection priority, evaluated each cycle:
  1. **stall**: pc_next = pc. RAS unchanged. All other requests ignored. ras_ovf and ras_unf are 0 next cycle.
  2. **ret_en**:
     - RAS non-empty: pc_next = top entry; pop (count−1).
     - RAS empty: pc_next = inc; ras_unf pulses; count stays 0.
  3. **call_en**:
     - pc_next = jump_target; push inc.
     - RAS full: the push overwrites the oldest entry; count stays RAS_DEPTH; ras_ovf pulses.
  4. **jump_en**: pc_next = jump_target.
  5. **branch_en**: pc_next = pc + branch_off.
  6. **otherwise**: pc_next = inc.
- Lower-priority requests asserted in the same cycle as a higher-priority one are dropped and have no side effects.
- RAS structure:
  - Circular buffer with a top pointer of log2(RAS_DEPTH) bits and a count of 0..RAS_DEPTH.
  - A push writes at top+1 and advances top; a pop reads at top and retreats top. Both wrap modulo RAS_DEPTH.
  - A call and a return never occur in the same cycle, because ret has priority.
- ras_empty and ras_full are combinational from the count.

## Timing

- Reset (asynchronous, rst_n low) forces:
  - pc = RESET_PC, RAS count = 0, top = 0;
  - ras_ovf = 0, ras_unf = 0;
  - ras_empty = 1, ras_full = 0.
- RAS entry contents are don't-care after reset.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge; pending requests are lost.
- After rst_n deasserts, the first rising edge applies the normal selection rules, so pc becomes RESET_PC+STEP if no request is asserted.
- Latency: a request sampled at edge N is visible on pc after edge N. pc_next reflects the request in the same cycle, combinationally.
- ras_ovf and ras_unf are asserted for exactly the one cycle following the offending edge.
- A return issued in the cycle immediately after a call pops that call's return address, because the RAS write is visible at the next edge.

## Test plan

- **Reset and increment:** WIDTH=32, STEP=1, RESET_PC=0x100; release reset, run 3 idle cycles -> pc reads 0x100, 0x101, 0x102, 0x103.
- **Branch and wrap-around:** pc=0x10, branch_off=0xFFFFFFF0 -> pc=0x0. Then from pc=0xFFFFFFFF with no request -> pc=0x0.
- **Priority:** at pc=0x20, assert stall with jump_en (jump_target=0x80) -> pc stays 0x20. Next cycle, jump_en and branch_en both asserted -> pc=0x80.
- **Call/return nesting:**
  - pc=0x10: call to 0x40; at 0x40: call to 0x60.
  - ret -> pc=0x41; ret -> pc=0x11; ras_empty=1.
- **Overflow and underflow (RAS_DEPTH=4):**
  - 5 calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_ovf pulses once, on the 5th call.
  - 4 rets -> return addresses 0x41, 0x31, 0x21, 0x11.
  - 5th ret -> ras_unf pulses; pc = the pc before that ret + 1.
- **Asynchronous reset mid-call:** assert rst_n low between edges while the RAS count is 2 -> pc=RESET_PC and ras_empty=1 immediately. A following ret -> ras_unf pulses.
